detect_frame_sched: RTL and testbench

DETECT_FRAME_SCHED -- requirements
Module: detect_frame_sched

---
 rtl/detect_pkg.sv | 33 +++
 rtl/detect_frame_sched.sv | 217 +++++++++++++++++++++
 tb/tb_detect_frame_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/detect_pkg.sv
// Shared definitions for the detected-droplet frame scheduler: state codes,
// header magic word, default geometry and small arithmetic helpers.
package detect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SIZE_RD   = 3'd1,
        ST_SIZE_CHK  = 3'd2,
        ST_DATA_RD   = 3'd3,
        ST_DATA_CAP  = 3'd4,
        ST_OUT       = 3'd5,
        ST_DRAIN_RD  = 3'd6,
        ST_DRAIN_CAP = 3'd7
    } state_t;

    localparam int DEF_PERIOD_NUM = 21;
    localparam int DEF_MAX_LINES  = 64;
    localparam int DEF_MIN_LINES  = 2;
    localparam int CNT_W          = 22;

    localparam logic [31:0] HDR_MAGIC = 32'hD40B_0001;

    // Word count of a droplet; period is a parameter-derived constant.
    function automatic logic [CNT_W-1:0] words_for(input logic [15:0] lines,
                                                   input logic [CNT_W-1:0] period);
        return CNT_W'(lines) * period;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/detect_frame_sched.sv
// Pulls a line count from the size FIFO, then forwards (or silently drains) that
// droplet's 128-bit words. Optional header beat per frame: DETECT_SCHED_HEADER_EN.
module detect_frame_sched
    import detect_pkg::*;
#(
    parameter int PERIOD_NUM = DEF_PERIOD_NUM,
    parameter int MAX_LINES  = DEF_MAX_LINES,
    parameter int MIN_LINES  = DEF_MIN_LINES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [31:0]  size_rddata,
    input  logic         size_rdempty,
    output logic         size_rdfifo,
    input  logic [127:0] data_rddata,
    input  logic         data_rdempty,
    output logic         data_rdfifo,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof,
    output logic         out_eof,
    output logic [15:0]  out_lines,
    output logic [15:0]  drop_count,
    output logic         busy,
    output logic [2:0]   state_out
);

    localparam logic [15:0]      MAX_L  = 16'(MAX_LINES);
    localparam logic [15:0]      MIN_L  = 16'(MIN_LINES);
    localparam logic [CNT_W-1:0] PERIOD = CNT_W'(PERIOD_NUM);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   counter_reg, counter_next;
    logic [15:0]        lines_reg, lines_next;
    logic               oversize_reg, oversize_next;
    logic [127:0]       data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               sof_reg, sof_next;
    logic               eof_reg, eof_next;
    logic [15:0]        drop_reg, drop_next;
    logic               size_rd, data_rd;
`ifdef DETECT_SCHED_HEADER_EN
    logic               hdr_reg, hdr_next;
    logic [15:0]        idx_reg, idx_next;
`else
    logic               first_reg, first_next;
`endif

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        lines_next    = lines_reg;
        oversize_next = oversize_reg;
        data_next     = data_reg;
        valid_next    = valid_reg;
        sof_next      = sof_reg;
        eof_next      = eof_reg;
        drop_next     = drop_reg;
        size_rd       = 1'b0;
        data_rd       = 1'b0;
`ifdef DETECT_SCHED_HEADER_EN
        hdr_next      = hdr_reg;
        idx_next      = idx_reg;
`else
        first_next    = first_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (!size_rdempty) begin
                    size_rd    = 1'b1;
                    state_next = ST_SIZE_RD;
                end
            end

            ST_SIZE_RD: begin
                lines_next    = size_rddata[15:0];
                oversize_next = |size_rddata[31:16];
                counter_next  = words_for(size_rddata[15:0], PERIOD);
                state_next    = ST_SIZE_CHK;
            end

            ST_SIZE_CHK: begin
                // Oversized or runt droplets still own data words that must be flushed.
                if (oversize_reg || (lines_reg > MAX_L) ||
                    ((lines_reg != 16'd0) && (lines_reg < MIN_L))) begin
                    drop_next  = sat_inc16(drop_reg);
                    state_next = ST_DRAIN_RD;
                end else if (lines_reg == 16'd0) begin
                    drop_next  = sat_inc16(drop_reg);
                    state_next = ST_IDLE;
                end else begin
`ifdef DETECT_SCHED_HEADER_EN
                    data_next  = {HDR_MAGIC, 16'd0, lines_reg, 16'd0, idx_reg, 32'd0};
                    valid_next = 1'b1;
                    sof_next   = 1'b1;
                    eof_next   = 1'b0;
                    hdr_next   = 1'b1;
                    idx_next   = idx_reg + 16'd1;
                    state_next = ST_OUT;
`else
                    first_next = 1'b1;
                    state_next = ST_DATA_RD;
`endif
                end
            end

            ST_DATA_RD: begin
                if (!data_rdempty) begin
                    data_rd    = 1'b1;
                    state_next = ST_DATA_CAP;
                end
            end

            ST_DATA_CAP: begin
                data_next  = data_rddata;
                valid_next = 1'b1;
                eof_next   = (counter_reg == CNT_W'(1));
`ifdef DETECT_SCHED_HEADER_EN
                sof_next   = 1'b0;
`else
                sof_next   = first_reg;
                first_next = 1'b0;
`endif
                state_next = ST_OUT;
            end

            ST_OUT: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    sof_next   = 1'b0;
                    eof_next   = 1'b0;
`ifdef DETECT_SCHED_HEADER_EN
                    if (hdr_reg) begin
                        hdr_next   = 1'b0;
                        state_next = ST_DATA_RD;
                    end else
`endif
                    begin
                        counter_next = counter_reg - CNT_W'(1);
                        state_next   = (counter_reg == CNT_W'(1)) ? ST_IDLE : ST_DATA_RD;
                    end
                end
            end

            ST_DRAIN_RD: begin
                // An oversize count whose low half is zero owns no words.
                if (counter_reg == '0) begin
                    state_next = ST_IDLE;
                end else if (!data_rdempty) begin
                    data_rd    = 1'b1;
                    state_next = ST_DRAIN_CAP;
                end
            end

            ST_DRAIN_CAP: begin
                counter_next = counter_reg - CNT_W'(1);
                state_next   = (counter_reg == CNT_W'(1)) ? ST_IDLE : ST_DRAIN_RD;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            counter_reg  <= '0;
            lines_reg    <= '0;
            oversize_reg <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            sof_reg      <= 1'b0;
            eof_reg      <= 1'b0;
            drop_reg     <= '0;
`ifdef DETECT_SCHED_HEADER_EN
            hdr_reg      <= 1'b0;
            idx_reg      <= '0;
`else
            first_reg    <= 1'b0;
`endif
        end else if (ce) begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            lines_reg    <= lines_next;
            oversize_reg <= oversize_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            sof_reg      <= sof_next;
            eof_reg      <= eof_next;
            drop_reg     <= drop_next;
`ifdef DETECT_SCHED_HEADER_EN
            hdr_reg      <= hdr_next;
            idx_reg      <= idx_next;
`else
            first_reg    <= first_next;
`endif
        end
    end

    // Read strobes are combinational so the FIFO word is present the next cycle;
    // gating with rst_n keeps them quiet for the whole reset window.
    assign size_rdfifo = size_rd & ce & rst_n;
    assign data_rdfifo = data_rd & ce & rst_n;

    assign out_data   = data_reg;
    assign out_valid  = valid_reg;
    assign out_sof    = sof_reg;
    assign out_eof    = eof_reg;
    assign out_lines  = lines_reg;
    assign drop_count = drop_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign state_out  = state_reg;

endmodule

// File: tb/tb_detect_frame_sched.sv
// Randomised scoreboard bench for detect_frame_sched: behavioural FIFOs feed the
// DUT, a frame-level model predicts beats and drops, a monitor compares.
`timescale 1ns/1ps
module tb_detect_frame_sched;
    import detect_pkg::*;

    localparam int PN = DEF_PERIOD_NUM;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b1;
    logic [31:0]  size_rddata = '0;
    logic         size_rdempty = 1'b1;
    logic         size_rdfifo;
    logic [127:0] data_rddata = '0;
    logic         data_rdempty = 1'b1;
    logic         data_rdfifo;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_sof;
    logic         out_eof;
    logic [15:0]  out_lines;
    logic [15:0]  drop_count;
    logic         busy;
    logic [2:0]   state_out;

    detect_frame_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .size_rddata  (size_rddata),
        .size_rdempty (size_rdempty),
        .size_rdfifo  (size_rdfifo),
        .data_rddata  (data_rddata),
        .data_rdempty (data_rdempty),
        .data_rdfifo  (data_rdfifo),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_lines    (out_lines),
        .drop_count   (drop_count),
        .busy         (busy),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         sof;
        logic         eof;
        logic [15:0]  lines;
    } beat_t;

    beat_t        exp_q[$];
    logic [31:0]  size_q[$];
    logic [127:0] data_q[$];

    int checks = 0;
    int fails = 0;
    int exp_drops = 0;
    int frame_idx = 0;
    int cyc = 0;
    int hold_until = 0;
    int beats_seen = 0;
    bit rnd_ready = 0;
    bit rnd_ce = 0;
    bit stall_en = 0;

    // Frame-level reference: a droplet is forwarded iff its 32-bit count is in
    // [2,64]; otherwise it is dropped and its words (low 16 bits * PN) are consumed.
    task automatic add_frame(input logic [31:0] sz);
        int           lines;
        int           nwords;
        bit           fwd;
        logic [127:0] w;
        beat_t        b;
        lines  = int'(sz[15:0]);
        nwords = lines * PN;
        fwd    = (sz[31:16] == 16'd0) && (lines >= DEF_MIN_LINES) && (lines <= DEF_MAX_LINES);
        size_q.push_back(sz);
        if (fwd) begin
`ifdef DETECT_SCHED_HEADER_EN
            b.data  = {32'hD40B_0001, 16'd0, sz[15:0], 16'd0, 16'(frame_idx), 32'd0};
            b.sof   = 1'b1;
            b.eof   = 1'b0;
            b.lines = sz[15:0];
            exp_q.push_back(b);
            frame_idx = (frame_idx + 1) % 65536;
`endif
        end else if (exp_drops < 65535) begin
            exp_drops++;
        end
        for (int i = 0; i < nwords; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            data_q.push_back(w);
            if (fwd) begin
                b.data  = w;
                b.eof   = (i == nwords - 1);
`ifdef DETECT_SCHED_HEADER_EN
                b.sof   = 1'b0;
`else
                b.sof   = (i == 0);
`endif
                b.lines = sz[15:0];
                exp_q.push_back(b);
            end
        end
        $display("frame queued: size=%08h words=%0d forward=%0d", sz, nwords, fwd);
    endtask

    // Behavioural FIFOs: flags refresh early in the cycle, reads take effect
    // mid-cycle so the word is presented throughout the following cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            size_rdempty = (size_q.size() == 0);
            data_rdempty = (data_q.size() == 0) || (stall_en && ($urandom % 4 == 0));
            @(negedge clk);
            if (size_rdfifo) begin
                checks++;
                if (size_q.size() == 0 || size_rdempty) begin
                    fails++;
                    $display("FAIL size_read_empty: size_rdfifo=1 required 0 (empty)");
                end else begin
                    size_rddata = size_q.pop_front();
                end
            end
            if (data_rdfifo) begin
                checks++;
                if (data_q.size() == 0 || data_rdempty) begin
                    fails++;
                    $display("FAIL data_read_empty: data_rdfifo=1 required 0 (empty/stalled)");
                end else begin
                    data_rddata = data_q.pop_front();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ce = rnd_ce ? ($urandom % 8 != 0) : 1'b1;
            if (cyc < hold_until) out_ready = 1'b0;
            else out_ready = rnd_ready ? ($urandom % 3 != 0) : 1'b1;
        end
    end

    // Monitor: compares every accepted beat against the scoreboard head.
    initial begin
        bit           prev_wait;
        logic [127:0] prev_data;
        beat_t        b;
        prev_wait = 0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait = 0;
            end else begin
                if (prev_wait) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== prev_data) begin
                        fails++;
                        $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h",
                                 out_valid, out_data, prev_data);
                    end
                end
                if (out_valid) begin
                    checks++;
                    if (data_rdfifo !== 1'b0) begin
                        fails++;
                        $display("FAIL read_while_valid: data_rdfifo=%0b required 0", data_rdfifo);
                    end
                end
                if (out_valid && out_ready && ce) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat: data=%h sof=%0b eof=%0b required no beat",
                                 out_data, out_sof, out_eof);
                    end else begin
                        b = exp_q.pop_front();
                        if (out_data !== b.data || out_sof !== b.sof || out_eof !== b.eof ||
                            out_lines !== b.lines) begin
                            fails++;
                            $display("FAIL beat: got data=%h sof=%0b eof=%0b lines=%0d required data=%h sof=%0b eof=%0b lines=%0d",
                                     out_data, out_sof, out_eof, out_lines, b.data, b.sof, b.eof, b.lines);
                        end else begin
                            $display("beat %0d: lines=%0d sof=%0b eof=%0b data=%h",
                                     beats_seen, out_lines, out_sof, out_eof, out_data);
                        end
                    end
                    beats_seen++;
                end
                prev_wait = out_valid && !(out_ready && ce);
                prev_data = out_data;
            end
        end
    end

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while ((size_q.size() != 0 || data_q.size() != 0 || exp_q.size() != 0 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            fails++;
            $display("FAIL %s_timeout: waited %0d cycles, required idle", tag, n);
        end
        repeat (4) @(negedge clk);
        check_val({tag, "_drop_count"}, 128'(drop_count), 128'(exp_drops));
        check_val({tag, "_busy"}, 128'(busy), 128'(0));
        check_val({tag, "_valid"}, 128'(out_valid), 128'(0));
        $display("%s done: drop_count=%0d beats_seen=%0d", tag, drop_count, beats_seen);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int n;
        n = 0;
        while (beats_seen < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL %s_beat_timeout: beats=%0d required %0d", tag, beats_seen, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 128'(out_valid), 128'(0));
        check_val({tag, "_sof_eof"}, 128'({out_sof, out_eof}), 128'(0));
        check_val({tag, "_rdfifo"}, 128'({size_rdfifo, data_rdfifo}), 128'(0));
        check_val({tag, "_busy"}, 128'(busy), 128'(0));
        check_val({tag, "_state"}, 128'(state_out), 128'(0));
        check_val({tag, "_data"}, out_data, 128'(0));
        check_val({tag, "_lines"}, 128'(out_lines), 128'(0));
        check_val({tag, "_drop"}, 128'(drop_count), 128'(0));
    endtask

    initial begin
        int c;
        int n;
        int base;
        logic [31:0] sz;
        int kind;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // 3-line droplet, ready high
        @(posedge clk); #1;
        add_frame(32'd3);
        wait_idle("size3", 5000);

        // zero-length droplet: dropped, 2 busy cycles, no data reads
        @(posedge clk); #1;
        add_frame(32'd0);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        c = 0;
        while (busy && c < 20) begin @(negedge clk); c++; end
        check_val("size0_busy_cycles", 128'(c), 128'(2));
        wait_idle("size0", 100);

        // oversize drained silently, then a normal frame
        @(posedge clk); #1;
        add_frame(32'd100);
        add_frame(32'd2);
        wait_idle("drain100", 12000);

        // backpressure held across beat 5
        @(posedge clk); #1;
        base = beats_seen;
        add_frame(32'd2);
        wait_beats(base + 5, "hold");
        hold_until = cyc + 12;
        wait_idle("hold", 5000);

        // data FIFO starving mid-frame
        stall_en = 1;
        @(posedge clk); #1;
        add_frame(32'd4);
        wait_idle("stall", 8000);
        stall_en = 0;

        // reset partway through a frame
        @(posedge clk); #1;
        base = beats_seen;
        add_frame(32'd2);
        wait_beats(base + 20, "rst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        size_q.delete();
        data_q.delete();
        exp_q.delete();
        exp_drops = 0;
        frame_idx = 0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        add_frame(32'd2);
        wait_idle("postrst", 5000);

        // randomised traffic with backpressure, clock-enable gaps and starvation
        rnd_ready = 1;
        rnd_ce = 1;
        stall_en = 1;
        for (int f = 0; f < 12; f++) begin
            @(posedge clk); #1;
            kind = int'($urandom % 10);
            case (kind)
                0:       sz = 32'd0;
                1:       sz = 32'd1;
                2:       sz = 32'd65;
                3:       sz = {16'($urandom_range(1, 255)), 16'($urandom_range(0, 2))};
                default: sz = 32'($urandom_range(2, 8));
            endcase
            add_frame(sz);
        end
        wait_idle("random", 40000);
        rnd_ready = 0;
        rnd_ce = 0;
        stall_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
